// File: rtl/adc_ser_emu.sv
// ADC serial-LVDS emulator: four channels shifted out MSB first, 16 bits per
// ENC period, with frame clock, ENC lock detection and misalignment counting.
module adc_ser_emu #(
   parameter int         DATA_BITS = 14,
   parameter logic [3:0] SYNC_DLY  = 4'd0,
   parameter logic [3:0] LOAD_POS  = 4'd7
) (
   input  logic                 CLK,
   input  logic                 RST_B,
   input  logic                 ENC,
   input  logic                 ENABLE,
   input  logic [1:0]           MODE,
   input  logic [DATA_BITS-1:0] DATA_CH0,
   input  logic [DATA_BITS-1:0] DATA_CH1,
   input  logic [DATA_BITS-1:0] DATA_CH2,
   input  logic [DATA_BITS-1:0] DATA_CH3,
   output logic [3:0]           DOUT,
   output logic                 FCO,
   output logic                 LOCKED,
   output logic [7:0]           SYNC_ERR_CNT
);

   localparam logic [DATA_BITS-1:0] ALT_EVEN = DATA_BITS'(16'h2AAA);
   localparam logic [DATA_BITS-1:0] ALT_ODD  = DATA_BITS'(16'h1555);
   localparam logic [3:0]           ALIGN_CNT = SYNC_DLY + 4'd15;

   logic [1:0]           enc_sync;
   logic                 enc_rise;
   logic [3:0]           cnt;
   logic                 load;
   logic [DATA_BITS-1:0] din  [4];
   logic [DATA_BITS-1:0] nxt  [4];
   logic [DATA_BITS-1:0] sr   [4];
   logic [DATA_BITS-1:0] ramp;
   logic                 phase;
   logic                 streak;
   logic                 locked;
   logic                 was_locked;
   logic [7:0]           err_cnt;

   assign enc_rise = enc_sync[0] & ~enc_sync[1];
   assign load     = (cnt == LOAD_POS);
   assign FCO      = cnt[3];
   assign LOCKED   = locked;
   assign SYNC_ERR_CNT = err_cnt;

   assign din[0] = DATA_CH0;
   assign din[1] = DATA_CH1;
   assign din[2] = DATA_CH2;
   assign din[3] = DATA_CH3;

   // Select the value each channel loads at the start of a frame.
   always_comb begin
      for (int n = 0; n < 4; n++) begin
         nxt[n] = '0;
         case (MODE)
            2'd0: nxt[n] = din[n];
            2'd1: nxt[n] = ramp + DATA_BITS'(n);
            2'd2: nxt[n] = phase ? ALT_ODD : ALT_EVEN;
            2'd3: nxt[n] = '0;
         endcase
      end
   end

   // Serial outputs are the register MSBs, gated by ENABLE.
   always_comb begin
      for (int n = 0; n < 4; n++) begin
         DOUT[n] = ENABLE & sr[n][DATA_BITS-1];
      end
   end

   // ENC synchronizer, bit counter, shift registers and pattern state.
   always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B) begin
         enc_sync <= '0;
         cnt      <= '0;
         ramp     <= '0;
         phase    <= 1'b0;
         for (int n = 0; n < 4; n++) sr[n] <= '0;
      end else begin
         enc_sync <= {enc_sync[0], ENC};
         cnt      <= enc_rise ? SYNC_DLY : cnt + 4'd1;
         if (load) begin
            for (int n = 0; n < 4; n++) sr[n] <= nxt[n];
            ramp  <= ramp + DATA_BITS'(1);
            phase <= ~phase;
         end else begin
            for (int n = 0; n < 4; n++)
               sr[n] <= {sr[n][DATA_BITS-2:0], 1'b0};
         end
      end
   end

   // Lock after two aligned ENC edges; count misaligned ones once ever locked.
   always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B) begin
         streak     <= 1'b0;
         locked     <= 1'b0;
         was_locked <= 1'b0;
         err_cnt    <= '0;
      end else if (enc_rise) begin
         if (cnt == ALIGN_CNT) begin
            streak <= 1'b1;
            if (streak) begin
               locked     <= 1'b1;
               was_locked <= 1'b1;
            end
         end else begin
            streak <= 1'b0;
            locked <= 1'b0;
            if (was_locked && err_cnt != 8'hFF)
               err_cnt <= err_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_adc_ser_emu.sv
// Directed testbench for adc_ser_emu: frame data, patterns, gating,
// lock/unlock behaviour, error saturation and mid-frame reset.
module tb_adc_ser_emu;

   logic        CLK;
   logic        RST_B;
   logic        ENC;
   logic        ENABLE;
   logic [1:0]  MODE;
   logic [13:0] DATA_CH0, DATA_CH1, DATA_CH2, DATA_CH3;
   logic [3:0]  DOUT;
   logic        FCO;
   logic        LOCKED;
   logic [7:0]  SYNC_ERR_CNT;

   int n_tests = 0;
   int n_fail  = 0;
   int enc_t   = 0;
   int enc_per = 16;
   int ph      = 0;

   adc_ser_emu dut (
      .CLK          (CLK),
      .RST_B        (RST_B),
      .ENC          (ENC),
      .ENABLE       (ENABLE),
      .MODE         (MODE),
      .DATA_CH0     (DATA_CH0),
      .DATA_CH1     (DATA_CH1),
      .DATA_CH2     (DATA_CH2),
      .DATA_CH3     (DATA_CH3),
      .DOUT         (DOUT),
      .FCO          (FCO),
      .LOCKED       (LOCKED),
      .SYNC_ERR_CNT (SYNC_ERR_CNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One CLK cycle: ENC driven at negedge, outputs sampled 1 after posedge.
   task automatic step();
      @(negedge CLK);
      ph  = enc_t;
      ENC = (enc_t < 8);
      enc_t = (enc_t + 1 >= enc_per) ? 0 : enc_t + 1;
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_j(input int target);
      int n = 0;
      do begin
         step();
         n++;
      end while (ph != target && n < 40);
      chk("wait_phase", ph, target);
   endtask

   task automatic do_reset();
      RST_B   = 1'b0;
      ENC     = 1'b0;
      enc_t   = 0;
      enc_per = 16;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_dout", DOUT, 0);
      chk("rst_fco", FCO, 0);
      chk("rst_lock", LOCKED, 0);
      chk("rst_err", SYNC_ERR_CNT, 0);
      @(negedge CLK);
      RST_B = 1'b1;
   endtask

   // Capture one 14-bit word per channel starting at the first MSB cycle.
   task automatic frame(input string tag, input int chg_at,
                        input logic [1:0] chg_mode,
                        input logic [13:0] e0, input logic [13:0] e1,
                        input logic [13:0] e2, input logic [13:0] e3);
      logic [13:0] w [4];
      logic [13:0] e [4];
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      for (int c = 0; c < 4; c++) w[c] = '0;
      wait_j(9);
      for (int b = 0; b < 14; b++) begin
         if (b > 0) step();
         for (int c = 0; c < 4; c++) w[c] = {w[c][12:0], DOUT[c]};
         if (b == 0) chk({tag, "_fco_hi"}, FCO, 1);
         if (b == 8) chk({tag, "_fco_lo"}, FCO, 0);
         if (b == chg_at) MODE = chg_mode;
      end
      for (int c = 0; c < 4; c++)
         chk($sformatf("%s_ch%0d", tag, c), w[c], e[c]);
      step();
      chk({tag, "_gap0"}, DOUT, 0);
      step();
      chk({tag, "_gap1"}, DOUT, 0);
      chk({tag, "_fco_pre"}, FCO, 0);
   endtask

   initial begin
      RST_B    = 1'b1;
      ENC      = 1'b0;
      ENABLE   = 1'b1;
      MODE     = 2'd0;
      DATA_CH0 = 14'h3ABC;
      DATA_CH1 = 14'h0001;
      DATA_CH2 = 14'h2000;
      DATA_CH3 = 14'h1234;
      #2;
      do_reset();

      frame("m0_f0", -1, 2'd0, 14'h3ABC, 14'h0001, 14'h2000, 14'h1234);
      chk("lock_one_edge", LOCKED, 0);
      frame("m0_f1", -1, 2'd0, 14'h3ABC, 14'h0001, 14'h2000, 14'h1234);
      chk("lock_two_edges", LOCKED, 1);
      chk("err_initial", SYNC_ERR_CNT, 0);

      wait_j(1);
      enc_per = 17;
      wait_j(0);
      enc_per = 16;
      wait_j(1);
      chk("unlock_stretch", LOCKED, 0);
      chk("err_stretch", SYNC_ERR_CNT, 1);
      wait_j(1);
      chk("relock_one", LOCKED, 0);
      wait_j(1);
      chk("relock_two", LOCKED, 1);

      enc_per = 17;
      repeat (10) wait_j(0);
      wait_j(1);
      chk("err_eleven", SYNC_ERR_CNT, 11);
      repeat (290) wait_j(0);
      enc_per = 16;
      wait_j(1);
      chk("err_saturate", SYNC_ERR_CNT, 255);
      chk("sat_unlocked", LOCKED, 0);
      wait_j(1);
      wait_j(1);
      chk("relock_sat", LOCKED, 1);

      wait_j(11);
      chk("pre_rst_bit", DOUT[0], 1);
      chk("pre_rst_fco", FCO, 1);
      #1 RST_B = 1'b0;
      #1;
      chk("midrst_dout", DOUT, 0);
      chk("midrst_fco", FCO, 0);
      chk("midrst_lock", LOCKED, 0);
      chk("midrst_err", SYNC_ERR_CNT, 0);

      MODE = 2'd1;
      do_reset();
      frame("ramp0", -1, 2'd0, 14'd0, 14'd1, 14'd2, 14'd3);
      frame("ramp1", -1, 2'd0, 14'd1, 14'd2, 14'd3, 14'd4);
      frame("ramp2", 5, 2'd2, 14'd2, 14'd3, 14'd4, 14'd5);
      frame("alt_odd", -1, 2'd0,
            14'h1555, 14'h1555, 14'h1555, 14'h1555);
      frame("alt_even", -1, 2'd0,
            14'h2AAA, 14'h2AAA, 14'h2AAA, 14'h2AAA);
      MODE = 2'd3;
      frame("zero", -1, 2'd0, 14'd0, 14'd0, 14'd0, 14'd0);
      MODE = 2'd1;
      frame("ramp6", -1, 2'd0, 14'd6, 14'd7, 14'd8, 14'd9);

      ENABLE = 1'b0;
      frame("dis0", -1, 2'd0, 14'd0, 14'd0, 14'd0, 14'd0);
      frame("dis1", -1, 2'd0, 14'd0, 14'd0, 14'd0, 14'd0);
      frame("dis2", -1, 2'd0, 14'd0, 14'd0, 14'd0, 14'd0);
      ENABLE = 1'b1;
      frame("ramp10", -1, 2'd0, 14'd10, 14'd11, 14'd12, 14'd13);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/adc_ser_emu.md
ADC_SER_EMU -- requirements
Module: adc_ser_emu

Interface
REQ-001 SHALL have parameter DATA_BITS, default 14: sample width per channel.
REQ-002 SHALL have parameter SYNC_DLY, default 0 (4 bits): bit-counter value loaded on each ENC rising edge.
REQ-003 SHALL have parameter LOAD_POS, default 7 (4 bits): bit-counter value at which a new sample is loaded.
REQ-004 SHALL have port CLK, input, 1 bit: bit clock (DCO), 16 per ENC period; the only clock.
REQ-005 SHALL have port RST_B, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port ENC, input, 1 bit: encode clock from the ADC receiver; asynchronous to CLK, sampled.
REQ-007 SHALL have port ENABLE, input, 1 bit: serial outputs active when high.
REQ-008 SHALL have port MODE, input, 2 bits: 0 = channel data, 1 = ramp, 2 = alternating, 3 = zero.
REQ-009 SHALL have ports DATA_CH0..DATA_CH3, input, DATA_BITS each: parallel samples.
REQ-010 SHALL have port DOUT, output, 4 bits: serial data, one bit per channel.
REQ-011 SHALL have port FCO, output, 1 bit: frame clock.
REQ-012 SHALL have port LOCKED, output, 1 bit: ENC period consistent with the 16-bit frame.
REQ-013 SHALL have port SYNC_ERR_CNT, output, 8 bits: count of misaligned ENC edges.

Function
REQ-014 SHALL pass ENC through a 2-flop synchronizer; enc_rise = sync[0] & ~sync[1], giving 2-3 CLK latency.
REQ-015 SHALL keep a 4-bit bit counter CNT: on enc_rise CNT <= SYNC_DLY, otherwise CNT <= CNT+1, wrapping 15->0.
REQ-016 SHALL drive FCO = CNT[3], registered or combinational from CNT, with no additional delay.
REQ-017 SHALL, when CNT == LOAD_POS, load each channel's DATA_BITS-wide shift register with the MODE-selected value.
REQ-018 SHALL, when CNT != LOAD_POS, shift each register left one bit with 0 fill.
REQ-019 SHALL drive DOUT[n] from the MSB of channel n's register (MSB first), gated to 0 when ENABLE is low.
REQ-020 SHALL keep CNT, the shift registers and the pattern state running regardless of ENABLE.
REQ-021 SHALL sample MODE only at a load cycle; a mid-frame MODE change affects the next frame only.
REQ-022 SHALL, in MODE 1, load RAMP + n into channel n (modulo 2^DATA_BITS), where RAMP is a DATA_BITS counter incremented after every load in any mode.
REQ-023 SHALL, in MODE 2, load 0x2AAA into all channels on even frames and 0x1555 on odd frames (DATA_BITS LSBs), with the phase bit toggling on every load.
REQ-024 SHALL, in MODE 3, load 0 into all channels.
REQ-025 SHALL treat an enc_rise as aligned when CNT == (SYNC_DLY+15) mod 16 in that cycle, i.e. exactly 16 CLK since the previous edge.
REQ-026 SHALL set LOCKED after 2 consecutive aligned edges and clear it on any misaligned edge.
REQ-027 SHALL increment SYNC_ERR_CNT, saturating at 255, on each misaligned edge while LOCKED is high or was high before that edge; edges before the first lock are not counted.
REQ-028 SHALL give priority to enc_rise when it coincides with a CNT wrap; the shift/load decision in that cycle uses the pre-update CNT.

Reset
REQ-029 SHALL, while RST_B is low, immediately clear CNT, the synchronizer, all shift registers, RAMP, the phase bit, LOCKED and SYNC_ERR_CNT, and hold DOUT = 0 and FCO = 0.
REQ-030 SHALL, on RST_B deassertion mid-frame, have CNT count from 0 until the next enc_rise re-aligns it; no partial-frame state survives.

Verification
REQ-031 SHALL be covered by: ENC = CLK/16 with defaults, MODE = 0, DATA_CH0 = 0x3ABC -> DOUT[0] emits 11101010111100 MSB first starting the cycle after CNT = 7, then 2 zero bits; FCO high while CNT is 8-15.
REQ-032 SHALL be covered by: steady ENC -> LOCKED = 1 after the 2nd aligned edge; then one ENC period stretched to 17 CLK -> LOCKED = 0 and SYNC_ERR_CNT = 1; after 2 more aligned edges -> LOCKED = 1 again.
REQ-033 SHALL be covered by: MODE = 1 from reset -> channel 0 emits 0, 1, 2, ... per frame and channel 3 emits 3, 4, 5, ...; MODE = 2 -> frames alternate 0x2AAA/0x1555.
REQ-034 SHALL be covered by: ENABLE = 0 for 3 frames -> DOUT = 0, FCO still toggles; re-enable -> the ramp value has advanced by 3.
REQ-035 SHALL be covered by: 300 forced misaligned edges after lock -> SYNC_ERR_CNT saturates at 255.
REQ-036 SHALL be covered by: RST_B pulsed low mid-shift -> DOUT, FCO and LOCKED are 0 within the same cycle; the first post-reset frame after an ENC edge is correct.
